// File: rtl/vram_arb_pkg.sv
// Shared types and geometry for the VRAM write arbiter: FSM state,
// stripe dimensions, pixel width and a saturating counter helper.
package vram_arb_pkg;

    localparam int unsigned VRAM_STRIPE_W = 640;
    localparam int unsigned VRAM_STRIPE_H = 32;
    localparam int unsigned VRAM_DEPTH    = VRAM_STRIPE_W * VRAM_STRIPE_H;
    localparam int unsigned VRAM_AW       = 15;
    localparam int unsigned PIX_W         = 12;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic [1:0] {RUN, DRAIN, SWAP} arb_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Writer-side request bus plus the registered VRAM write port.
// slave: the arbiter; master: the writers and VRAM side.
interface vram_wr_if
    import vram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = VRAM_AW,
    parameter int unsigned DW   = PIX_W
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;

    modport master (
        output req, req_addr, req_data,
        input  gnt, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/vram_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping modulo NREQ; returns a one-hot grant and the winner index.
module rr_picker #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   winner,
    output logic            valid
);

    always_comb begin
        int unsigned idx;
        gnt    = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!valid && req[PW'(idx)]) begin
                valid            = 1'b1;
                winner           = PW'(idx);
                gnt[PW'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter for the ping-pong VRAM write port with frame-tick bank swap.
// Define VRAM_ARB_STATS_EN to add swap/skip/miss saturating counters.
module vram_write_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned AW    = VRAM_AW,
    parameter int unsigned DW    = PIX_W,
    parameter int unsigned DEPTH = VRAM_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       win_en,
    input  logic       frame_tick,
    input  logic       frame_ready,
    vram_wr_if.slave   bus,
    output logic       bank_sel,
    output logic       swap_pulse,
    output logic       addr_err
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] swap_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [CNT_W-1:0] miss_cnt
`endif
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state;
    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   winner;
    logic            pick_valid;
    logic            grant_c;
    logic            win_oor;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .gnt    (pick_gnt),
        .winner (winner),
        .valid  (pick_valid)
    );

    // Grants only in RUN with the write window open; suppressed during reset.
    assign grant_c  = !reset && (state == RUN) && win_en && pick_valid;
    assign bus.gnt  = grant_c ? pick_gnt : '0;
    assign win_addr = bus.req_addr[winner * AW +: AW];
    assign win_data = bus.req_data[winner * DW +: DW];
    assign win_oor  = 32'(win_addr) >= DEPTH;

    // Write register, round-robin pointer and sticky range error.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            addr_err    <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            bus.wr_en <= grant_c && !win_oor;
            if (grant_c && !win_oor) begin
                bus.wr_addr <= win_addr;
                bus.wr_data <= win_data;
            end
            if (grant_c && win_oor)
                addr_err <= 1'b1;
            if (grant_c)
                rr_ptr <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
        end
    end

    // Frame FSM: DRAIN lets the last registered write retire before the swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            bank_sel   <= 1'b0;
            swap_pulse <= 1'b0;
        end else begin
            swap_pulse <= 1'b0;
            case (state)
                RUN: begin
                    if (frame_tick)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (frame_ready) begin
                        state      <= SWAP;
                        bank_sel   <= ~bank_sel;
                        swap_pulse <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                SWAP:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            swap_cnt <= '0;
            skip_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == DRAIN && frame_ready)
                swap_cnt <= sat_inc(swap_cnt);
            if (state == DRAIN && !frame_ready)
                skip_cnt <= sat_inc(skip_cnt);
            if (state != RUN && frame_tick)
                miss_cnt <= sat_inc(miss_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: expected writes are queued at grant
// time and compared when the registered write port presents them.
module tb_vram_write_arbiter;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned AW    = 15;
    localparam int unsigned DW    = 12;
    localparam int unsigned DEPTH = 20480;

    typedef struct packed {
        logic          en;
        logic          oor;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_t;

    logic clk;
    logic reset;
    logic win_en;
    logic frame_tick;
    logic frame_ready;
    logic bank_sel;
    logic swap_pulse;
    logic addr_err;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0] swap_cnt;
    logic [15:0] skip_cnt;
    logic [15:0] miss_cnt;
`endif

    vram_wr_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    vram_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .win_en      (win_en),
        .frame_tick  (frame_tick),
        .frame_ready (frame_ready),
        .bus         (bus),
        .bank_sel    (bank_sel),
        .swap_pulse  (swap_pulse),
        .addr_err    (addr_err)
`ifdef VRAM_ARB_STATS_EN
        ,
        .swap_cnt    (swap_cnt),
        .skip_cnt    (skip_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    int unsigned   n_fail   = 0;
    sb_t           sb[$];
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    logic          exp_err   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    // One clock: check outputs mid-cycle, queue the expected write, advance to edge+1.
    task automatic cycle(input string tag, input logic [NREQ-1:0] exp_gnt,
                         input logic exp_bank, input logic exp_swp);
        sb_t e;
        sb_t n;
        #3;
        e = (sb.size() > 0) ? sb.pop_front() : sb_t'('0);
        if (e.en) begin
            last_addr = e.addr;
            last_data = e.data;
        end
        exp_err = exp_err | e.oor;
        chk({tag, " wr_en"},      32'(bus.wr_en),   32'(e.en));
        chk({tag, " wr_addr"},    32'(bus.wr_addr), 32'(last_addr));
        chk({tag, " wr_data"},    32'(bus.wr_data), 32'(last_data));
        chk({tag, " addr_err"},   32'(addr_err),    32'(exp_err));
        chk({tag, " gnt"},        32'(bus.gnt),     32'(exp_gnt));
        chk({tag, " bank_sel"},   32'(bank_sel),    32'(exp_bank));
        chk({tag, " swap_pulse"}, 32'(swap_pulse),  32'(exp_swp));
        n = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (exp_gnt[i]) begin
                n.addr = bus.req_addr[i*AW +: AW];
                n.data = bus.req_data[i*DW +: DW];
                n.oor  = 32'(n.addr) >= DEPTH;
                n.en   = !n.oor;
            end
        end
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        win_en      = 1'b0;
        frame_tick  = 1'b0;
        frame_ready = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle("reset", 3'b000, 1'b0, 1'b0);

        // Full contention: strict rotation.
        set_req(0, 15'd100, 12'h111);
        set_req(1, 15'd200, 12'h222);
        set_req(2, 15'd300, 12'h333);
        bus.req = 3'b111;
        win_en  = 1'b1;
        cycle("rr1", 3'b001, 1'b0, 1'b0);
        cycle("rr2", 3'b010, 1'b0, 1'b0);
        cycle("rr3", 3'b100, 1'b0, 1'b0);
        cycle("rr4", 3'b001, 1'b0, 1'b0);
        cycle("rr5", 3'b010, 1'b0, 1'b0);
        cycle("rr6", 3'b100, 1'b0, 1'b0);

        // Write window gating holds the pointer.
        bus.req = 3'b101;
        cycle("win_a", 3'b001, 1'b0, 1'b0);
        win_en = 1'b0;
        cycle("win_off", 3'b000, 1'b0, 1'b0);
        win_en = 1'b1;
        cycle("win_b", 3'b100, 1'b0, 1'b0);
        bus.req = '0;
        cycle("idle1", 3'b000, 1'b0, 1'b0);

        // Frame tick without a ready back buffer: no swap.
        frame_tick  = 1'b1;
        frame_ready = 1'b0;
        cycle("skip_tick", 3'b000, 1'b0, 1'b0);
        frame_tick = 1'b0;
        cycle("skip_drain", 3'b000, 1'b0, 1'b0);
        bus.req = 3'b010;
        cycle("skip_run", 3'b010, 1'b0, 1'b0);
`ifdef VRAM_ARB_STATS_EN
        chk("skip_cnt", 32'(skip_cnt), 32'd1);
`endif
        bus.req = '0;
        cycle("idle2", 3'b000, 1'b0, 1'b0);

        // Out-of-range address and the last valid address.
        set_req(0, 15'd20480, 12'hABC);
        bus.req = 3'b001;
        cycle("oor", 3'b001, 1'b0, 1'b0);
        set_req(0, 15'd20479, 12'h5A5);
        cycle("edge", 3'b001, 1'b0, 1'b0);
        bus.req = '0;
        cycle("edge_wr", 3'b000, 1'b0, 1'b0);
        cycle("err_hold", 3'b000, 1'b0, 1'b0);

        // Swap, then reset during the SWAP cycle.
        frame_tick  = 1'b1;
        frame_ready = 1'b1;
        cycle("sw_tick", 3'b000, 1'b0, 1'b0);
        frame_tick = 1'b0;
        bus.req    = 3'b100;
        cycle("sw_drain", 3'b000, 1'b0, 1'b0);
        reset = 1'b1;
        cycle("sw_swap", 3'b000, 1'b1, 1'b1);
        exp_err   = 1'b0;
        last_addr = '0;
        last_data = '0;
        sb.delete();
        cycle("rst_hold", 3'b000, 1'b0, 1'b0);
`ifdef VRAM_ARB_STATS_EN
        chk("rst swap_cnt", 32'(swap_cnt), 32'd0);
        chk("rst skip_cnt", 32'(skip_cnt), 32'd0);
`endif
        reset = 1'b0;
        cycle("rst_run", 3'b100, 1'b0, 1'b0);

        // Tick with a simultaneous grant; ticks in DRAIN/SWAP are ignored.
        set_req(0, 15'd4660, 12'hF0F);
        set_req(1, 15'd777, 12'h0F0);
        bus.req     = 3'b001;
        frame_tick  = 1'b1;
        frame_ready = 1'b1;
        cycle("fr_tick", 3'b001, 1'b0, 1'b0);
        bus.req = 3'b010;
        cycle("fr_drain", 3'b000, 1'b0, 1'b0);
        cycle("fr_swap", 3'b000, 1'b1, 1'b1);
        frame_tick = 1'b0;
        cycle("fr_run", 3'b010, 1'b1, 1'b0);
        bus.req     = '0;
        frame_ready = 1'b0;
        cycle("fr_idle", 3'b000, 1'b1, 1'b0);
        cycle("fr_end", 3'b000, 1'b1, 1'b0);
`ifdef VRAM_ARB_STATS_EN
        chk("end swap_cnt", 32'(swap_cnt), 32'd1);
        chk("end skip_cnt", 32'(skip_cnt), 32'd0);
        chk("end miss_cnt", 32'(miss_cnt), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
